// File: rtl/ecc_scrub_pkg.sv
// Shared widths and FSM state encoding for the background ECC scrubber.
package ecc_scrub_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CHK_W  = 8;

   typedef logic [2:0] state_t;

   localparam state_t StIdle  = 3'd0;
   localparam state_t StRead  = 3'd1;
   localparam state_t StWait  = 3'd2;
   localparam state_t StCheck = 3'd3;
   localparam state_t StWrite = 3'd4;
   localparam state_t StNext  = 3'd5;

endpackage

// File: rtl/ecc_scrub_timer.sv
// Interval counter between word scrubs: counts while enabled, stops at the
// terminal value and flags it until cleared.
module ecc_scrub_timer #(
   parameter int unsigned INTERVAL = 256
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic clr_i,
   output logic term_o
);

   localparam int unsigned CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign term_o = (cnt_q == CW'(INTERVAL - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !term_o) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background scrub sequencer: reads each word, runs it past the external
// corrector, writes back corrected data and logs the correction.
module ecc_scrub_ctrl
   import ecc_scrub_pkg::*;
#(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned INTERVAL = 256,
   parameter int unsigned CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scrub_en,
   input  logic              mem_busy,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [CHK_W-1:0]  mem_wchk,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [CHK_W-1:0]  mem_rchk,
   output logic              corr_en,
   output logic [DATA_W-1:0] corr_data,
   output logic [CHK_W-1:0]  corr_chk,
   input  logic [DATA_W-1:0] corr_out,
   output logic [CNT_W-1:0]  err_count,
   output logic [ADDR_W-1:0] last_err_addr,
   output logic              pass_done
);

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   raw_data_q, raw_data_d;
   logic [CHK_W-1:0]    raw_chk_q, raw_chk_d;
   logic [DATA_W-1:0]   corr_q, corr_d;
   logic [CNT_W-1:0]    err_count_q, err_count_d;
   logic [ADDR_W-1:0]   last_err_addr_q, last_err_addr_d;

   logic tmr_en, tmr_clr, tmr_term;
   logic issue;

   // The port is only ours in READ/WRITE cycles where the host is idle.
   assign issue   = ((state_q == StRead) || (state_q == StWrite)) && !mem_busy;
   assign tmr_en  = (state_q == StIdle) && scrub_en;
   assign tmr_clr = tmr_en && tmr_term;

   ecc_scrub_timer #(
      .INTERVAL (INTERVAL)
   ) u_timer (
      .clk_i  (clk),
      .rst_i  (rst),
      .en_i   (tmr_en),
      .clr_i  (tmr_clr),
      .term_o (tmr_term)
   );

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      raw_data_d      = raw_data_q;
      raw_chk_d       = raw_chk_q;
      corr_d          = corr_q;
      err_count_d     = err_count_q;
      last_err_addr_d = last_err_addr_q;
      case (state_q)
         StIdle: begin
            if (tmr_clr) state_d = StRead;
         end
         StRead: begin
            if (!mem_busy) state_d = StWait;
         end
         StWait: begin
            if (mem_rvalid) begin
               raw_data_d = mem_rdata;
               raw_chk_d  = mem_rchk;
               state_d    = StCheck;
            end
         end
         StCheck: begin
            corr_d  = corr_out;
            // Check-bit-only errors leave data unchanged and skip writeback.
            state_d = (corr_out != raw_data_q) ? StWrite : StNext;
         end
         StWrite: begin
            if (!mem_busy) begin
               if (err_count_q != {CNT_W{1'b1}}) err_count_d = err_count_q + CNT_W'(1);
               last_err_addr_d = addr_q;
               state_d         = StNext;
            end
         end
         StNext: begin
            addr_d  = (addr_q == LastAddr) ? '0 : addr_q + ADDR_W'(1);
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= StIdle;
         addr_q          <= '0;
         raw_data_q      <= '0;
         raw_chk_q       <= '0;
         corr_q          <= '0;
         err_count_q     <= '0;
         last_err_addr_q <= '0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         raw_data_q      <= raw_data_d;
         raw_chk_q       <= raw_chk_d;
         corr_q          <= corr_d;
         err_count_q     <= err_count_d;
         last_err_addr_q <= last_err_addr_d;
      end
   end

   always_comb begin
      mem_req       = issue;
      mem_we        = issue && (state_q == StWrite);
      mem_addr      = issue ? addr_q : '0;
      mem_wdata     = mem_we ? corr_q : '0;
      mem_wchk      = mem_we ? raw_chk_q : '0;
      corr_en       = (state_q == StCheck);
      corr_data     = raw_data_q;
      corr_chk      = raw_chk_q;
      err_count     = err_count_q;
      last_err_addr = last_err_addr_q;
      pass_done     = (state_q == StNext) && (addr_q == LastAddr);
   end

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Scoreboard bench for ecc_scrub_ctrl: directed memory images, a corrector
// stub, and a monitor that checks every access and pass pulse in order.
module tb_ecc_scrub_ctrl;

   localparam int unsigned ADDR_W   = 4;
   localparam int unsigned DEPTH    = 4;
   localparam int unsigned INTERVAL = 4;
   localparam int unsigned CNT_W    = 2;

   logic              clk, rst, scrub_en, mem_busy;
   logic              mem_req, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [7:0]        mem_wchk;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;
   logic [7:0]        mem_rchk;
   logic              corr_en;
   logic [31:0]       corr_data;
   logic [7:0]        corr_chk;
   logic [31:0]       corr_out;
   logic [CNT_W-1:0]  err_count;
   logic [ADDR_W-1:0] last_err_addr;
   logic              pass_done;

   ecc_scrub_ctrl #(
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .INTERVAL (INTERVAL),
      .CNT_W    (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .scrub_en      (scrub_en),
      .mem_busy      (mem_busy),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_wchk      (mem_wchk),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata),
      .mem_rchk      (mem_rchk),
      .corr_en       (corr_en),
      .corr_data     (corr_data),
      .corr_chk      (corr_chk),
      .corr_out      (corr_out),
      .err_count     (err_count),
      .last_err_addr (last_err_addr),
      .pass_done     (pass_done)
   );

   // Corrector stub: check bits 111xxxxx mark data bit xxxxx as flipped.
   assign corr_out = (corr_chk[7:5] == 3'b111) ? (corr_data & ~(32'h1 << corr_chk[4:0]))
                                               : corr_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic              is_pass;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
      logic [7:0]        wchk;
   } ev_t;

   ev_t         exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] mem_d[DEPTH];
   logic [7:0]  mem_c[DEPTH];
   int          mem_lat = 1;
   logic        mon_on = 1'b0;
   logic [31:0] last_rd = '0;
   logic [7:0]  last_rc = '0;
   logic [1:0]  rd_a;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_r(input logic [ADDR_W-1:0] a);
      exp_q.push_back('{is_pass: 1'b0, we: 1'b0, addr: a, wdata: 32'h0, wchk: 8'h0});
   endtask

   task automatic push_w(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [7:0] c);
      exp_q.push_back('{is_pass: 1'b0, we: 1'b1, addr: a, wdata: d, wchk: c});
   endtask

   task automatic push_p();
      exp_q.push_back('{is_pass: 1'b1, we: 1'b0, addr: '0, wdata: 32'h0, wchk: 8'h0});
   endtask

   task automatic drive();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_read(input logic [ADDR_W-1:0] a);
      bit found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         if (mem_req && !mem_we && mem_addr == a) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL wait_read: no read of addr %0d, expected one within 300 cycles", a);
      end
   endtask

   task automatic drain();
      bit empty = 1'b0;
      for (int i = 0; i < 500 && !empty; i++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0) empty = 1'b1;
      end
      checks++;
      if (!empty) begin
         errors++;
         $display("FAIL drain: %0d events outstanding, expected 0", exp_q.size());
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_mem_req"}, mem_req, 0);
      chk({tag, "_mem_we"}, mem_we, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_mem_wchk"}, mem_wchk, 0);
      chk({tag, "_corr_en"}, corr_en, 0);
      chk({tag, "_corr_data"}, corr_data, 0);
      chk({tag, "_corr_chk"}, corr_chk, 0);
      chk({tag, "_err_count"}, err_count, 0);
      chk({tag, "_last_err_addr"}, last_err_addr, 0);
      chk({tag, "_pass_done"}, pass_done, 0);
   endtask

   // Memory read port model: response mem_lat cycles after the issue cycle.
   initial begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      mem_rchk   = '0;
      forever begin
         @(negedge clk);
         if (mon_on && mem_req && !mem_we) begin
            rd_a = mem_addr[1:0];
            repeat (mem_lat) @(posedge clk);
            #1;
            mem_rvalid = 1'b1;
            mem_rdata  = mem_d[rd_a];
            mem_rchk   = mem_c[rd_a];
            last_rd    = mem_d[rd_a];
            last_rc    = mem_c[rd_a];
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
         end
      end
   end

   // Monitor: pops one expected event per access or pass pulse.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            if (mem_busy) chk("no_req_while_busy", mem_req, 0);
            if (corr_en) begin
               chk("corr_data", corr_data, last_rd);
               chk("corr_chk", corr_chk, last_rc);
            end
            if (mem_req || pass_done) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_event: req=%0b we=%0b addr=%0d pass=%0b, expected none",
                           mem_req, mem_we, mem_addr, pass_done);
               end else begin
                  e = exp_q.pop_front();
                  chk("event_is_pass", pass_done, e.is_pass);
                  if (!e.is_pass) begin
                     chk("mem_we", mem_we, e.we);
                     chk("mem_addr", mem_addr, e.addr);
                     if (e.we) begin
                        chk("mem_wdata", mem_wdata, e.wdata);
                        chk("mem_wchk", mem_wchk, e.wchk);
                     end
                  end
               end
               if (mem_req && mem_we) begin
                  mem_d[mem_addr[1:0]] = mem_wdata;
                  mem_c[mem_addr[1:0]] = mem_wchk;
               end
            end
         end
      end
   end

   initial begin
      #300000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      rst      = 1'b1;
      scrub_en = 1'b0;
      mem_busy = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = 32'hA5A5_0000 | i;
         mem_c[i] = 8'(i);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");

      // Clean pass: first read exactly INTERVAL cycles after release.
      push_r(0); push_r(1); push_r(2); push_r(3); push_p();
      drive();
      rst      = 1'b0;
      scrub_en = 1'b1;
      mon_on   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("first_read_latency", mem_req, (i == 4) ? 1 : 0);
      end
      drain();
      chk("clean_err_count", err_count, 0);

      // Single correctable word at address 2.
      mem_d[2] = 32'h0000_0001;
      mem_c[2] = 8'hE0;
      push_r(0); push_r(1); push_r(2); push_w(2, 32'h0, 8'hE0); push_r(3); push_p();
      drain();
      chk("err_count_one", err_count, 1);
      chk("last_err_addr_2", last_err_addr, 2);

      // Host contention, overlapping interval expiry, then stalling the write.
      mem_d[1] = 32'h0000_0100;
      mem_c[1] = 8'hE8;
      push_r(0); push_r(1); push_w(1, 32'h0, 8'hE8); push_r(2); push_r(3); push_p();
      drive();
      mem_busy = 1'b1;
      repeat (12) drive();
      mem_busy = 1'b0;
      @(negedge clk);
      chk("read_after_busy_req", mem_req, 1);
      chk("read_after_busy_addr", mem_addr, 0);
      wait_read(1);
      drive();
      mem_busy = 1'b1;
      repeat (10) drive();
      mem_busy = 1'b0;
      @(negedge clk);
      chk("write_after_busy", mem_req && mem_we, 1);
      drain();
      chk("err_count_two", err_count, 2);
      chk("last_err_addr_1", last_err_addr, 1);

      // scrub_en dropped mid-word: word completes, then IDLE holds.
      push_r(0); push_r(1); push_r(2); push_r(3); push_p();
      wait_read(0);
      drive();
      scrub_en = 1'b0;
      repeat (20) drive();
      chk("paused_outstanding", exp_q.size(), 4);
      scrub_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("resume_latency", mem_req, (i == 4) ? 1 : 0);
      end
      drain();

      // Saturation: three more corrections on a 2-bit counter already at 2.
      mem_d[0] = 32'h2; mem_c[0] = 8'hE1;
      mem_d[1] = 32'h4; mem_c[1] = 8'hE2;
      mem_d[3] = 32'h8; mem_c[3] = 8'hE3;
      push_r(0); push_w(0, 32'h0, 8'hE1); push_r(1); push_w(1, 32'h0, 8'hE2);
      push_r(2); push_r(3); push_w(3, 32'h0, 8'hE3); push_p();
      drain();
      chk("err_count_sat", err_count, 3);
      chk("last_err_addr_3", last_err_addr, 3);

      // Reset in WAIT with a late read return.
      mem_d[0] = 32'h10;
      mem_c[0] = 8'hE4;
      mem_lat  = 3;
      push_r(0);
      wait_read(0);
      drive();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_zero("rst_in_wait");
      drive();
      rst     = 1'b0;
      mem_lat = 1;

      // Reset in a stalled WRITE: the write must never issue.
      push_r(0);
      wait_read(0);
      drive();
      mem_busy = 1'b1;
      repeat (4) drive();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_zero("rst_in_write");
      chk("no_write_on_reset", mem_d[0], 32'h10);
      drive();
      rst      = 1'b0;
      mem_busy = 1'b0;
      push_r(0); push_w(0, 32'h0, 8'hE4); push_r(1); push_r(2); push_r(3); push_p();
      drain();
      chk("post_reset_err_count", err_count, 1);
      chk("post_reset_last_err", last_err_addr, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ecc_scrub_ctrl.md
Name: ecc_scrub_ctrl

Overview:
- Background scrub sequencer for the 32-bit single-error-correcting datapath: 32 data bits and 8 check bits in, 32 corrected data bits out, plus one enable.
- Walks every word of an ECC-protected memory, reads data and check bits, and presents them to the corrector.
- When the corrected word differs from the raw word, writes the corrected word back with the original check bits and logs the error.
- Yields the memory port to host traffic whenever the host owns it.

Parameters:
- ADDR_W, 10, memory address width.
- DEPTH, 1024, number of words scrubbed per pass (1..2^ADDR_W).
- INTERVAL, 256, idle cycles between consecutive word scrubs (>=1).
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- scrub_en  in  1  scrubbing enabled.
- mem_busy  in  1  host owns the memory port this cycle; the scrubber must not issue.
- mem_req  out  1  scrubber memory access strobe, one cycle per access.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  32  write data (corrected word).
- mem_wchk  out  8  write check bits (original check bits).
- mem_rvalid  in  1  read return strobe.
- mem_rdata  in  32  read data.
- mem_rchk  in  8  read check bits.
- corr_en  out  1  corrector enable; 1 only in CHECK.
- corr_data  out  32  raw data to the corrector.
- corr_chk  out  8  raw check bits to the corrector.
- corr_out  in  32  corrected data from the corrector (combinational).
- err_count  out  CNT_W  corrected-word count, saturating.
- last_err_addr  out  ADDR_W  address of the most recent correction.
- pass_done  out  1  one-cycle pulse after word DEPTH-1 completes.

Behaviour:
Reset:
- All outputs 0, state IDLE, address 0, interval counter 0, data/check registers 0.

States:
- IDLE: interval counter increments while scrub_en=1 and holds while scrub_en=0. When the counter reaches INTERVAL-1 with scrub_en=1, the counter clears and the FSM goes to READ.
- READ: mem_req=1, mem_we=0, mem_addr=addr only in a cycle where mem_busy=0. With mem_busy=1, outputs stay 0 and the FSM stays in READ. After issuing, go to WAIT.
- WAIT: on mem_rvalid=1, register mem_rdata/mem_rchk and go to CHECK. mem_rvalid seen in any other state is ignored.
- CHECK: exactly one cycle. corr_en=1; corr_data/corr_chk driven from the registers. Register corr_out. If corr_out != raw data, go to WRITE; otherwise go to NEXT. A check-bit-only error leaves the data unchanged and gets no writeback.
- WRITE: mem_req=1, mem_we=1, mem_wdata=registered corr_out, mem_wchk=registered raw check bits, gated on mem_busy=0 exactly as in READ. In the issue cycle, err_count increments (holds at 2^CNT_W-1) and last_err_addr is loaded with addr. Then go to NEXT.
- NEXT: if addr==DEPTH-1, addr<=0 and pass_done=1 for this cycle; otherwise addr<=addr+1. Go to IDLE.

Minimum per-word latency, no contention:
- INTERVAL cycles idle, 1 READ, then read latency + 1 in WAIT, 1 CHECK, optional 1 WRITE, 1 NEXT.

Boundary conditions:
- scrub_en deasserting mid-word: the current word still completes through NEXT. Only IDLE honours scrub_en.
- mem_busy may stall READ/WRITE indefinitely; no timeout.
- mem_busy and the interval expiry in the same cycle: enter READ and wait there.
- rst in any state: immediate return to reset values, no completion of an in-flight write. err_count and last_err_addr clear.
- corr_en=0 outside CHECK; corr_data/corr_chk hold their last values.

Decomposition:
- Package ecc_scrub_pkg: DATA_W=32, CHK_W=8, state enum {IDLE, READ, WAIT, CHECK, WRITE, NEXT}.
- Sub-module ecc_scrub_timer: interval counter with enable, clear and terminal flag.
- The corrector netlist is instantiated beside this block at the parent level, not inside it.

Test Plan:
1. Reset, scrub_en=1, INTERVAL=4, DEPTH=4, clean memory (corr_out == rdata) -> reads at addresses 0,1,2,3; no writes; pass_done pulses once, in the NEXT cycle of address 3; err_count=0.
2. Address 2 holds data 0x0000_0001 and corr_out returns 0x0000_0000 -> one write to address 2 with wdata=0x0000_0000 and original wchk; err_count=1; last_err_addr=2.
3. mem_busy=1 for 10 cycles during READ, then during WRITE -> no mem_req while busy; each access issued in the first cycle after busy drops; address order unchanged.
4. scrub_en dropped the cycle after READ issues -> WAIT/CHECK/NEXT complete, addr advances by 1, FSM stays in IDLE with the interval counter frozen until scrub_en returns.
5. Force err_count to 0xFFFE, then inject 3 correctable words -> err_count saturates at 0xFFFF.
6. rst asserted in WAIT and in WRITE -> next cycle all outputs 0 and state IDLE; late mem_rvalid ignored; no write issued.
